accumulator_bank: RTL and testbench

Parametrised accumulator bank for the next venera CPU generation. It replaces the single 8-bit AC with NUM_ACC selectable accumulators of DATA_W bits and a Z/N/C flag register. It also adds a LIFO save/restore stack so the sequencer can preserve and restore an accumulator and its flags around subroutine or interrupt entry. It sits between the ALU output, the memory read path and the ALU A-operand input.

---
 rtl/venera_acc_pkg.sv | 32 +++
 rtl/accumulator_bank_if.sv | 39 +++
 rtl/acc_stack.sv | 62 ++++++
 rtl/accumulator_bank.sv | 89 ++++++++
 tb/tb_accumulator_bank.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/venera_acc_pkg.sv
// Shared definitions for the venera accumulator bank: flag bit positions,
// stack entry sizing and a constant-friendly ceiling log2.
package venera_acc_pkg;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int NUM_FLAGS = 3;

  // Where the active accumulator's next value comes from this cycle
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM,
    SRC_POP
  } wr_src_e;

  // A saved entry is {C, N, Z, data}
  function automatic int entry_w(input int data_w);
    return data_w + NUM_FLAGS;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accumulator_bank_if.sv
// Bus between the sequencer/datapath and the accumulator bank: write sources,
// stack controls, the selected accumulator read-out and status.
interface accumulator_bank_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_ACC = 4
);
  import venera_acc_pkg::*;

  localparam int SEL_W = clog2(NUM_ACC);

  logic [SEL_W-1:0]  i_sel;
  logic              i_alu_valid;
  logic [DATA_W-1:0] i_alu_data;
  logic              i_alu_carry;
  logic              i_mem_valid;
  logic [DATA_W-1:0] i_mem_data;
  logic              i_push;
  logic              i_pop;
  logic [DATA_W-1:0] o_dout;
  logic              o_zero;
  logic              o_neg;
  logic              o_carry;
  logic              o_full;
  logic              o_empty;
  logic              o_stack_err;

  modport master (
    output i_sel, i_alu_valid, i_alu_data, i_alu_carry,
           i_mem_valid, i_mem_data, i_push, i_pop,
    input  o_dout, o_zero, o_neg, o_carry, o_full, o_empty, o_stack_err
  );

  modport slave (
    input  i_sel, i_alu_valid, i_alu_data, i_alu_carry,
           i_mem_valid, i_mem_data, i_push, i_pop,
    output o_dout, o_zero, o_neg, o_carry, o_full, o_empty, o_stack_err
  );

endinterface

// File: rtl/acc_stack.sv
// LIFO save stack for accumulator+flag entries, with a sticky error flag for
// pushes into a full stack and pops from an empty one.
module acc_stack
  import venera_acc_pkg::*;
#(
  parameter int ENTRY_W = 11,
  parameter int DEPTH   = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [ENTRY_W-1:0] i_entry,
  output logic [ENTRY_W-1:0] o_top,
  output logic               o_pop_ok,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_err
);

  localparam int PTR_W  = clog2(DEPTH + 1);
  localparam int ADDR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_ptr;
  logic               r_err;

  logic               w_push_ok;
  logic               w_err_set;
  logic [ADDR_W-1:0]  w_wr_idx;
  logic [ADDR_W-1:0]  w_rd_idx;

  assign o_full  = (r_ptr == PTR_W'(DEPTH));
  assign o_empty = (r_ptr == '0);
  assign o_err   = r_err;

  // Simultaneous push and pop cancel each other without raising an error
  assign w_push_ok = i_push & ~i_pop & ~o_full;
  assign o_pop_ok  = i_pop & ~i_push & ~o_empty;
  assign w_err_set = (i_push & ~i_pop & o_full) | (i_pop & ~i_push & o_empty);

  assign w_wr_idx = r_ptr[ADDR_W-1:0];
  assign w_rd_idx = w_wr_idx - ADDR_W'(1);
  assign o_top    = r_mem[w_rd_idx];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_push_ok) r_ptr <= r_ptr + PTR_W'(1);
      else if (o_pop_ok) r_ptr <= r_ptr - PTR_W'(1);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Storage needs no reset: the pointer alone decides what is valid
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[w_wr_idx] <= i_entry;
  end

endmodule

// File: rtl/accumulator_bank.sv
// Bank of selectable accumulators with a shared Z/N/C flag register and a
// save/restore stack; ALU writes beat memory writes, which beat pops.
module accumulator_bank
  import venera_acc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_ACC     = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  accumulator_bank_if.slave  bus
);

  localparam int ENTRY_W = entry_w(DATA_W);

  logic [DATA_W-1:0]    r_acc [NUM_ACC];
  logic [NUM_FLAGS-1:0] r_flags;

  logic                 w_sel_ok;
  logic [DATA_W-1:0]    w_cur;
  logic [ENTRY_W-1:0]   w_entry;
  logic [ENTRY_W-1:0]   w_top;
  logic                 w_pop_ok;
  wr_src_e              w_src;
  logic [DATA_W-1:0]    w_wdata;
  logic [NUM_FLAGS-1:0] w_wflags;

  // Unused select codes read as zero and never write
  assign w_sel_ok = (32'(bus.i_sel) < NUM_ACC);
  assign w_cur    = w_sel_ok ? r_acc[bus.i_sel] : '0;
  assign w_entry  = {r_flags, w_cur};

  assign bus.o_dout  = w_cur;
  assign bus.o_zero  = r_flags[FLAG_Z];
  assign bus.o_neg   = r_flags[FLAG_N];
  assign bus.o_carry = r_flags[FLAG_C];

  acc_stack #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (STACK_DEPTH)
  ) u_stack (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_push   (bus.i_push),
    .i_pop    (bus.i_pop),
    .i_entry  (w_entry),
    .o_top    (w_top),
    .o_pop_ok (w_pop_ok),
    .o_full   (bus.o_full),
    .o_empty  (bus.o_empty),
    .o_err    (bus.o_stack_err)
  );

  // A pop that loses to a data write still consumes its stack entry
  always_comb begin
    w_src    = SRC_NONE;
    w_wdata  = w_cur;
    w_wflags = r_flags;
    if (bus.i_alu_valid) begin
      w_src            = SRC_ALU;
      w_wdata          = bus.i_alu_data;
      w_wflags[FLAG_Z] = (bus.i_alu_data == '0);
      w_wflags[FLAG_N] = bus.i_alu_data[DATA_W-1];
      w_wflags[FLAG_C] = bus.i_alu_carry;
    end else if (bus.i_mem_valid) begin
      w_src            = SRC_MEM;
      w_wdata          = bus.i_mem_data;
      w_wflags[FLAG_Z] = (bus.i_mem_data == '0);
      w_wflags[FLAG_N] = bus.i_mem_data[DATA_W-1];
    end else if (w_pop_ok) begin
      w_src    = SRC_POP;
      w_wdata  = w_top[DATA_W-1:0];
      w_wflags = w_top[ENTRY_W-1:DATA_W];
    end
    if (!w_sel_ok) w_src = SRC_NONE;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
      r_flags <= NUM_FLAGS'(1 << FLAG_Z);
    end else if (w_src != SRC_NONE) begin
      r_acc[bus.i_sel] <= w_wdata;
      r_flags          <= w_wflags;
    end
  end

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed and randomised checks of accumulator_bank against a queue-based
// behavioural model of the accumulators, flags and save stack.
module tb_accumulator_bank;

  localparam int DATA_W      = 8;
  localparam int NUM_ACC     = 4;
  localparam int STACK_DEPTH = 4;

  logic clock;
  logic reset;

  int compareCount;
  int failCount;

  logic [7:0]  accModel [NUM_ACC];
  logic        zModel, nModel, cModel, errModel;
  logic [10:0] stackModel [$];

  accumulator_bank_if #(.DATA_W(DATA_W), .NUM_ACC(NUM_ACC)) ifc ();

  accumulator_bank #(
    .DATA_W      (DATA_W),
    .NUM_ACC     (NUM_ACC),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .i_clk   (clock),
    .i_reset (reset),
    .bus     (ifc)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic modelReset();
    for (int i = 0; i < NUM_ACC; i++) accModel[i] = 8'h00;
    zModel   = 1'b1;
    nModel   = 1'b0;
    cModel   = 1'b0;
    errModel = 1'b0;
    stackModel.delete();
  endtask

  // One clock of the bank's rules, evaluated on the values before the edge
  task automatic modelStep(input logic [1:0] sel, input logic aluV, input logic [7:0] aluD,
                           input logic carry, input logic memV, input logic [7:0] memD,
                           input logic push, input logic pop);
    logic [10:0] saved;
    logic [10:0] popped;
    logic        popOk;
    saved  = {cModel, nModel, zModel, accModel[sel]};
    popped = '0;
    popOk  = 1'b0;
    if (push && !pop) begin
      if (stackModel.size() == STACK_DEPTH) errModel = 1'b1;
      else stackModel.push_back(saved);
    end
    if (pop && !push) begin
      if (stackModel.size() == 0) errModel = 1'b1;
      else begin
        popped = stackModel.pop_back();
        popOk  = 1'b1;
      end
    end
    if (aluV) begin
      accModel[sel] = aluD;
      zModel = (aluD == 8'h00);
      nModel = aluD[7];
      cModel = carry;
    end else if (memV) begin
      accModel[sel] = memD;
      zModel = (memD == 8'h00);
      nModel = memD[7];
    end else if (popOk) begin
      accModel[sel] = popped[7:0];
      zModel = popped[8];
      nModel = popped[9];
      cModel = popped[10];
    end
  endtask

  task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, "/dout"},  32'(ifc.o_dout),      32'(accModel[ifc.i_sel]));
    checkOne({tag, "/zero"},  32'(ifc.o_zero),      32'(zModel));
    checkOne({tag, "/neg"},   32'(ifc.o_neg),       32'(nModel));
    checkOne({tag, "/carry"}, 32'(ifc.o_carry),     32'(cModel));
    checkOne({tag, "/full"},  32'(ifc.o_full),      32'(stackModel.size() == STACK_DEPTH));
    checkOne({tag, "/empty"}, 32'(ifc.o_empty),     32'(stackModel.size() == 0));
    checkOne({tag, "/err"},   32'(ifc.o_stack_err), 32'(errModel));
  endtask

  // Sweeps every select value through the read mux, then restores the select
  task automatic checkAll(input string tag);
    logic [1:0] keep;
    keep = ifc.i_sel;
    for (int s = 0; s < NUM_ACC; s++) begin
      ifc.i_sel = 2'(s);
      #1;
      checkOne($sformatf("%s/acc%0d", tag, s), 32'(ifc.o_dout), 32'(accModel[s]));
    end
    ifc.i_sel = keep;
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic aluV, input logic [7:0] aluD,
                               input logic carry, input logic memV, input logic [7:0] memD,
                               input logic push, input logic pop);
    @(negedge clock);
    ifc.i_sel       = sel;
    ifc.i_alu_valid = aluV;
    ifc.i_alu_data  = aluD;
    ifc.i_alu_carry = carry;
    ifc.i_mem_valid = memV;
    ifc.i_mem_data  = memD;
    ifc.i_push      = push;
    ifc.i_pop       = pop;
    @(posedge clock);
    modelStep(sel, aluV, aluD, carry, memV, memD, push, pop);
    #1;
    ifc.i_alu_valid = 1'b0;
    ifc.i_mem_valid = 1'b0;
    ifc.i_push      = 1'b0;
    ifc.i_pop       = 1'b0;
  endtask

  task automatic resetPulse();
    @(negedge clock);
    reset = 1'b1;
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    compareCount = 0;
    failCount    = 0;
    reset        = 1'b1;
    ifc.i_sel       = '0;
    ifc.i_alu_valid = 1'b0;
    ifc.i_alu_data  = '0;
    ifc.i_alu_carry = 1'b0;
    ifc.i_mem_valid = 1'b0;
    ifc.i_mem_data  = '0;
    ifc.i_push      = 1'b0;
    ifc.i_pop       = 1'b0;
    modelReset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("reset");
    checkAll("reset");
    checkOne("reset/zero_const", 32'(ifc.o_zero), 32'd1);

    // ALU write then memory write on accumulator 2
    applyStimulus(2'd2, 1'b1, 8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("alu_0x80");
    checkOne("alu_0x80/dout_const", 32'(ifc.o_dout), 32'h80);
    applyStimulus(2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("mem_0x00");
    checkOne("mem_0x00/carry_held", 32'(ifc.o_carry), 32'd1);
    checkAll("mem_0x00");

    // ALU beats memory in the same cycle
    applyStimulus(2'd1, 1'b1, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    checkOutput("alu_over_mem");
    checkOne("alu_over_mem/const", 32'(ifc.o_dout), 32'h11);

    // Save, overwrite, restore
    applyStimulus(2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    applyStimulus(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("push_5a");
    applyStimulus(2'd0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("overwrite");
    applyStimulus(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("pop_5a");
    checkOne("pop_5a/const", 32'(ifc.o_dout), 32'h5A);

    // Overflow and LIFO order
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(2'd3, 1'b0, 8'h00, 1'b0, 1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
      applyStimulus(2'd3, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput($sformatf("push%0d", i));
    end
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(2'd3, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput($sformatf("pop%0d", i));
    end
    checkOne("lifo/last_const", 32'(ifc.o_dout), 32'h11);

    // Asynchronous reset between edges with two entries stored
    resetPulse();
    applyStimulus(2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("two_pushed");
    #3;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("async_reset");
    checkAll("async_reset");
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("pop_after_reset");
    checkOne("pop_after_reset/err_const", 32'(ifc.o_stack_err), 32'd1);

    // Randomised traffic, with periodic resets to clear the sticky error
    for (int blk = 0; blk < 4; blk++) begin
      resetPulse();
      for (int n = 0; n < 100; n++) begin
        applyStimulus(2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0), 8'($urandom),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        checkOutput($sformatf("rand%0d_%0d", blk, n));
      end
      checkAll($sformatf("rand%0d_end", blk));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
